// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training sequencer.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        NEXT,
        EPOCH_END,
        FINISH
    } state_t;

    localparam int unsigned ADDR_W    = 10;
    localparam logic [3:0]  CTRL_RUN  = 4'b1111;
    localparam logic [3:0]  CTRL_IDLE = 4'b0000;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero once it gets there.
module seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/perceptron_train_seq.sv
// Training sequencer: steps the core through every sample, counts errors per
// epoch and stops on convergence, epoch limit or a watchdog timeout.
module perceptron_train_seq
    import perceptron_pkg::*;
#(
    parameter int unsigned ADDR_W     = perceptron_pkg::ADDR_W,
    parameter int unsigned N_SAMPLES  = 500,
    parameter int unsigned MAX_EPOCHS = 16,
    parameter int unsigned SETTLE_CYC = 5,
    parameter logic [3:0]  CTRL_RUN   = perceptron_pkg::CTRL_RUN,
    parameter int unsigned WDOG_CYC   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              core_rst,
    output logic [3:0]        control,
    output logic [ADDR_W-1:0] sample_addr,
    input  logic              core_done,
    input  logic              core_err,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timeout,
    output logic [7:0]        epoch_cnt,
    output logic [ADDR_W:0]   err_cnt
);

    localparam int unsigned      SETTLE_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned      WDOG_W    = $clog2(WDOG_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    state_t     state_q, state_d;
    logic       settle_load, settle_en, settle_zero;
    logic       wdog_load, wdog_en, wdog_zero;
    logic [8:0] epoch_nxt;
    logic       last_epoch;

    assign epoch_nxt  = {1'b0, epoch_cnt} + 9'd1;
    assign last_epoch = (epoch_nxt == 9'(MAX_EPOCHS));

    // Timers are loaded with N-1 so PREP lasts exactly SETTLE_CYC cycles and
    // RUN may last up to WDOG_CYC cycles before the watchdog fires.
    seq_timer #(.W(SETTLE_W)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .en       (settle_en),
        .load_val (SETTLE_W'(SETTLE_CYC - 1)),
        .zero     (settle_zero)
    );

    seq_timer #(.W(WDOG_W)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wdog_load),
        .en       (wdog_en),
        .load_val (WDOG_W'(WDOG_CYC - 1)),
        .zero     (wdog_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        core_rst    = 1'b0;
        control     = CTRL_IDLE;
        done        = 1'b0;
        settle_load = 1'b0;
        settle_en   = 1'b0;
        wdog_load   = 1'b0;
        wdog_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PREP;
                    settle_load = 1'b1;
                end
            end
            PREP: begin
                core_rst = 1'b1;
                if (settle_zero) begin
                    state_d   = RUN;
                    wdog_load = 1'b1;
                end else begin
                    settle_en = 1'b1;
                end
            end
            RUN: begin
                control = CTRL_RUN;
                if (core_done)      state_d = NEXT;
                else if (wdog_zero) state_d = FINISH;
                else                wdog_en = 1'b1;
            end
            NEXT: begin
                if (sample_addr < LAST_ADDR) begin
                    state_d     = PREP;
                    settle_load = 1'b1;
                end else begin
                    state_d = EPOCH_END;
                end
            end
            EPOCH_END: begin
                if (err_cnt == '0 || last_epoch) begin
                    state_d = FINISH;
                end else begin
                    state_d     = PREP;
                    settle_load = 1'b1;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_addr <= '0;
            epoch_cnt   <= '0;
            err_cnt     <= '0;
            converged   <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sample_addr <= '0;
                        epoch_cnt   <= '0;
                        err_cnt     <= '0;
                        converged   <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_done)      err_cnt <= err_cnt + (ADDR_W+1)'(core_err);
                    else if (wdog_zero) timeout <= 1'b1;
                end
                NEXT: begin
                    if (sample_addr < LAST_ADDR) sample_addr <= sample_addr + ADDR_W'(1);
                end
                EPOCH_END: begin
                    if (epoch_cnt != 8'hFF) epoch_cnt <= epoch_cnt + 8'd1;
                    if (err_cnt == '0) begin
                        converged <= 1'b1;
                    end else if (!last_epoch) begin
                        sample_addr <= '0;
                        err_cnt     <= '0;
                    end
                end
                FINISH: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_train_seq.sv
// Scoreboard bench for perceptron_train_seq: a reference model queues the
// expected sample order and final results; a monitor checks what the DUT shows.
module tb_perceptron_train_seq;

    localparam int unsigned NS     = 4;
    localparam int unsigned MAXE   = 3;
    localparam int unsigned SETTLE = 5;
    localparam int unsigned WDOG   = 8;
    localparam int unsigned AW     = 10;
    localparam logic [3:0]  CRUN   = 4'b1111;

    logic          clk = 1'b0;
    logic          rst, start, core_rst, core_done, core_err;
    logic          busy, done, converged, timeout;
    logic [3:0]    control;
    logic [AW-1:0] sample_addr;
    logic [7:0]    epoch_cnt;
    logic [AW:0]   err_cnt;

    typedef struct {
        int epochs;
        int errs;
        bit conv;
        bit tmo;
        int run_len;
    } res_t;

    int   exp_addr_q[$];
    res_t exp_res_q[$];
    bit   err_pat[NS*MAXE];
    int   lat_cur, run_count, done_count;
    bit   glitch_en;
    int   n_vec, n_err;

    always #5 clk = ~clk;

    perceptron_train_seq #(
        .ADDR_W     (AW),
        .N_SAMPLES  (NS),
        .MAX_EPOCHS (MAXE),
        .SETTLE_CYC (SETTLE),
        .CTRL_RUN   (CRUN),
        .WDOG_CYC   (WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core_rst    (core_rst),
        .control     (control),
        .sample_addr (sample_addr),
        .core_done   (core_done),
        .core_err    (core_err),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .timeout     (timeout),
        .epoch_cnt   (epoch_cnt),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_core_rst"}, core_rst, 0);
        check({tag, "_control"}, control, 0);
        check({tag, "_addr"}, sample_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_converged"}, converged, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_epoch_cnt"}, epoch_cnt, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Training as plain nested loops over epochs and samples; lat==0 means the
    // core never answers, so the first sample times out.
    task automatic ref_run(input int lat);
        res_t r;
        int   k;
        int   errs;
        r = '{default: 0};
        k = 0;
        for (int e = 0; e < int'(MAXE); e++) begin
            errs = 0;
            for (int a = 0; a < int'(NS); a++) begin
                exp_addr_q.push_back(a);
                if (lat == 0) begin
                    r.epochs  = e;
                    r.errs    = errs;
                    r.tmo     = 1'b1;
                    r.run_len = int'(WDOG);
                    exp_res_q.push_back(r);
                    return;
                end
                errs += int'(err_pat[k]);
                k++;
            end
            r.epochs = e + 1;
            r.errs   = errs;
            if (errs == 0) begin
                r.conv = 1'b1;
                break;
            end
        end
        r.run_len = lat;
        exp_res_q.push_back(r);
    endtask

    task automatic do_run(input int lat, input bit glitch);
        int n0;
        lat_cur   = lat;
        glitch_en = glitch;
        run_count = 0;
        ref_run(lat);
        n0 = done_count;
        start = 1'b1;
        tick;
        start = 1'b0;
        if (glitch) begin
            repeat (10) tick;
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_count == n0; i++) tick;
        check("run_completed", done_count, n0 + 1);
        repeat (3) tick;
    endtask

    // Core stand-in: answers lat cycles into each RUN with the scripted error
    // bit; core_err toggles randomly whenever core_done is low.
    initial begin : core_model
        int run_age, prep_age, run_idx;
        run_age   = 0;
        prep_age  = 0;
        run_idx   = 0;
        core_done = 1'b0;
        core_err  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_err  = 1'($urandom_range(0, 1));
            if (control === CRUN) begin
                run_age++;
                if (run_age == 1) begin
                    run_idx = run_count;
                    run_count++;
                end
                if (lat_cur != 0 && run_age == lat_cur) begin
                    core_done = 1'b1;
                    core_err  = (run_idx < int'(NS*MAXE)) ? err_pat[run_idx] : 1'b0;
                end
            end else begin
                run_age = 0;
            end
            if (core_rst === 1'b1) begin
                prep_age++;
                if (glitch_en && prep_age == 2) begin
                    core_done = 1'b1;
                    core_err  = 1'b1;
                end
            end else begin
                prep_age = 0;
            end
        end
    end

    initial begin : monitor
        bit   prev_run, done_pend;
        int   prst, run_len, a;
        res_t r;
        prev_run  = 1'b0;
        done_pend = 1'b0;
        prst      = 0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_run  = 1'b0;
                done_pend = 1'b0;
                prst      = 0;
                run_len   = 0;
            end else begin
                if (done_pend) begin
                    check("done_one_cycle", done, 0);
                    check("busy_falls", busy, 0);
                    done_pend = 1'b0;
                end
                if (control === CRUN) begin
                    if (!prev_run) begin
                        check("run_expected", 64'(exp_addr_q.size() != 0), 1);
                        if (exp_addr_q.size() != 0) begin
                            a = exp_addr_q.pop_front();
                            check("sample_addr", sample_addr, a);
                            check("settle_len", prst, SETTLE);
                        end
                        prst    = 0;
                        run_len = 0;
                    end
                    run_len++;
                end
                if (core_rst === 1'b1) begin
                    prst++;
                    check("control_in_prep", control, 0);
                end
                prev_run = (control === CRUN);
                if (done === 1'b1) begin
                    check("done_expected", 64'(exp_res_q.size() != 0), 1);
                    if (exp_res_q.size() != 0) begin
                        r = exp_res_q.pop_front();
                        check("epoch_cnt", epoch_cnt, r.epochs);
                        check("err_cnt", err_cnt, r.errs);
                        check("converged", converged, r.conv);
                        check("timeout", timeout, r.tmo);
                        check("last_run_len", run_len, r.run_len);
                        check("busy_at_done", busy, 1);
                    end
                    done_count++;
                    done_pend = 1'b1;
                end
            end
        end
    end

    initial begin : sim_limit
        #2000000;
        $display("FAIL sim_limit: got no finish, expected finish before time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int n0;
        rst        = 1'b1;
        start      = 1'b0;
        lat_cur    = 3;
        glitch_en  = 1'b0;
        run_count  = 0;
        done_count = 0;
        n_vec      = 0;
        n_err      = 0;
        foreach (err_pat[k]) err_pat[k] = 1'b0;
        repeat (2) tick;
        check_idle("reset");
        rst = 1'b0;
        tick;

        rst   = 1'b1;
        start = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        tick;
        check_idle("start_with_rst");

        // clean convergence in one epoch
        foreach (err_pat[k]) err_pat[k] = 1'b0;
        do_run(3, 1'b0);

        // epoch limit: addr 2 always wrong
        foreach (err_pat[k]) err_pat[k] = ((k % NS) == 2);
        do_run(2, 1'b0);

        // errors on addrs 0 and 3 in epoch 1 only, minimum core latency
        foreach (err_pat[k]) err_pat[k] = 1'b0;
        err_pat[0] = 1'b1;
        err_pat[3] = 1'b1;
        do_run(1, 1'b0);

        // core never finishes
        do_run(0, 1'b0);

        // same as epoch-limit run, with a stray start and a PREP-time core_done
        foreach (err_pat[k]) err_pat[k] = ((k % NS) == 2);
        do_run(2, 1'b1);

        // reset mid-RUN aborts without a done pulse
        lat_cur   = 0;
        glitch_en = 1'b0;
        run_count = 0;
        exp_addr_q.push_back(0);
        n0    = done_count;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 50 && control !== CRUN; i++) tick;
        check("reached_run", control, CRUN);
        tick;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        check_idle("abort");
        repeat (10) tick;
        check("no_done_after_abort", done_count, n0);

        repeat (12) begin
            foreach (err_pat[k]) err_pat[k] = ($urandom_range(0, 3) == 0);
            do_run(int'($urandom_range(1, WDOG)), 1'b0);
        end

        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("result_queue_drained", exp_res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perceptron_train_seq.md
Name: perceptron_train_seq

Overview:
- Training sequencer directly upstream of core_perceptron; replaces the bench-driven per-sample loop.
- Walks sample addresses over the x1/x2/label memories and, for each sample, pulses the core's reset/load phase, then runs it with the control word.
- Waits for the core's per-sample completion and counts misclassifications per epoch.
- Repeats epochs until an epoch has zero errors (converged) or MAX_EPOCHS is reached.

Parameters:
- ADDR_W, 10, sample address width; matches the x1/x2/label counter width.
- N_SAMPLES, 500, samples per epoch; addresses 0..N_SAMPLES-1. Legal range 1..2^ADDR_W.
- MAX_EPOCHS, 16, epoch limit; legal range 1..255.
- SETTLE_CYC, 5, cycles core_rst is held high per sample.
- CTRL_RUN, 4'b1111, control word driven while the core runs.
- WDOG_CYC, 1024, maximum cycles spent in RUN before a timeout.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to begin training; ignored unless idle.
- core_rst, out, 1, drives the core's rst.
- control, out, 4, drives the core's control.
- sample_addr, out, ADDR_W, drives x1_cnt, x2_cnt and label_cnt.
- core_done, in, 1, core finished the current sample; one-cycle pulse.
- core_err, in, 1, sample was misclassified (weights updated); qualified by core_done.
- busy, out, 1, high from start acceptance until FINISH.
- done, out, 1, one-cycle pulse on completion.
- converged, out, 1, sticky; last epoch had zero errors.
- timeout, out, 1, sticky; watchdog expired.
- epoch_cnt, out, 8, number of completed epochs.
- err_cnt, out, ADDR_W+1, errors in the current epoch or, after done, in the last epoch.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0 (core_rst=0, control=0, sample_addr=0, flags and counters 0). Reset mid-training aborts immediately, with no done pulse.
- IDLE:
  - start=1 moves to PREP.
  - On that transition: sample_addr<=0, epoch_cnt<=0, err_cnt<=0, converged<=0, timeout<=0, busy<=1.
- PREP:
  - core_rst=1, control=0, for exactly SETTLE_CYC cycles (internal counter).
  - Then go to RUN.
  - sample_addr is stable throughout PREP and RUN.
- RUN:
  - core_rst=0, control=CTRL_RUN.
  - On core_done=1: err_cnt += core_err; go to NEXT.
  - Watchdog counts RUN cycles. If it reaches WDOG_CYC without core_done: timeout<=1, go to FINISH.
  - A core_done seen in any state other than RUN is ignored.
- NEXT:
  - If sample_addr < N_SAMPLES-1: sample_addr+1, go to PREP.
  - Otherwise go to EPOCH_END.
- EPOCH_END:
  - epoch_cnt += 1 (8-bit, saturates at 255).
  - If err_cnt==0: converged<=1, go to FINISH.
  - Else if epoch_cnt+1 == MAX_EPOCHS: go to FINISH.
  - Else: sample_addr<=0, err_cnt<=0, go to PREP.
- FINISH:
  - Control outputs idle (core_rst=0, control=0).
  - done=1 for one cycle; busy<=0; return to IDLE.
  - err_cnt, epoch_cnt, converged and timeout hold until the next accepted start or reset.
- Timing:
  - Per-sample overhead: SETTLE_CYC + 1 (NEXT) cycles, plus core latency.
  - Minimum per-sample latency: SETTLE_CYC + 2 cycles, when core_done arrives on the first RUN cycle.
- Boundary cases:
  - start while busy: ignored.
  - start and rst asserted together: rst wins.
  - N_SAMPLES=1: every epoch is PREP→RUN→NEXT→EPOCH_END.
  - err_cnt width ADDR_W+1 holds N_SAMPLES without wrap.

Decomposition:
- Shared package perceptron_pkg: state enum (IDLE, PREP, RUN, NEXT, EPOCH_END, FINISH), CTRL_RUN/CTRL_IDLE constants, ADDR_W default.
- Sub-module seq_timer: loadable down-counter with zero flag, instanced twice (settle counter, watchdog).
- FSM and counters stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RUN → next cycle all outputs 0, state IDLE, no done pulse.
- Convergence: N_SAMPLES=4, core_done 3 cycles after RUN entry, core_err=0 always → 4 samples at addrs 0,1,2,3; core_rst high exactly 5 cycles before each RUN; done pulses with converged=1, epoch_cnt=1, err_cnt=0.
- Epoch limit: N_SAMPLES=4, MAX_EPOCHS=3, core_err=1 on addr 2 every epoch → done after 12 samples; epoch_cnt=3, err_cnt=1, converged=0.
- Multi-epoch convergence: errors on addrs 0 and 3 in epoch 1, none in epoch 2 → sample_addr wraps 3→0; err_cnt resets; final epoch_cnt=2, converged=1.
- Watchdog: WDOG_CYC=8, core_done never asserted → timeout=1 after 8 RUN cycles; done pulses; busy falls.
- Handshake robustness: start pulsed while busy, and core_done pulsed during PREP → both ignored; sample sequence and counts unchanged versus the clean run.
